// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the decoded key outputs.
// Ports: kr (row sense, active-low), kc (column drive, active-low), press, scan_code, key_valid, key_rel
interface keypad_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int CW   = $clog2(ROWS * COLS)
);
    logic [ROWS-1:0] kr;
    logic [COLS-1:0] kc;
    logic            press;
    logic [CW-1:0]   scan_code;
    logic            key_valid;
    logic            key_rel;
    modport master (input kr, output kc, press, scan_code, key_valid, key_rel);
    modport slave  (output kr, input kc, press, scan_code, key_valid, key_rel);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning, debounced single-key matrix keypad decoder.
// Ports: clk, rst (sync active-high), kp.master (kr in; kc, press, scan_code, key_valid, key_rel out)
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input logic              clk,
    input logic              rst,
    keypad_scanner_if.master kp
);
    localparam int CW  = $clog2(ROWS * COLS);
    localparam int CLW = $clog2(COLS);
    localparam int DW  = $clog2(SCAN_DIV);
    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;
    state_t          state_q, state_d;
    logic [ROWS-1:0] s1_q, krs_q, cand_q, cand_d, low;
    logic [DW-1:0]   div_q;
    logic [CLW-1:0]  col_q, col_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [CW-1:0]   code_q, code_d, code;
    logic            press_q, press_d, kv_q, kv_d, rel_q, rel_d;
    logic            tick, one_low, all_hi, adv, acc, rls;
    int              row;
    assign tick    = div_q == DW'(SCAN_DIV - 1);
    assign low     = ~krs_q;
    // exactly one row low: nonzero and a power of two
    assign one_low = |low && ~|(low & (low - ROWS'(1)));
    assign all_hi  = &krs_q;
    assign col_d   = adv ? (col_q == CLW'(COLS - 1) ? '0 : col_q + CLW'(1)) : col_q;
    assign kp.kc        = ~(COLS'(1) << col_q);
    assign kp.press     = press_q;
    assign kp.scan_code = code_q;
    assign kp.key_valid = kv_q;
    assign kp.key_rel   = rel_q;
    always_comb begin
        row = 0;
        for (int r = 0; r < ROWS; r++)
            if (!krs_q[r]) row = r;
        code = CW'(row * COLS + int'(col_q));
    end
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        press_d = press_q;
        code_d  = code_q;
        kv_d    = 1'b0;
        rel_d   = 1'b0;
        adv     = 1'b0;
        acc     = 1'b0;
        rls     = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (one_low) begin
                        cand_d  = krs_q;
                        cnt_d   = 4'd1;
                        state_d = DEB_PRESS;
                        acc     = DEBOUNCE == 1;
                    end else begin
                        adv = 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (krs_q == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        acc   = cnt_d == 4'(DEBOUNCE);
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                        adv     = 1'b1;
                    end
                end
                HELD: begin
                    if (all_hi) begin
                        cnt_d   = 4'd1;
                        state_d = DEB_REL;
                        rls     = DEBOUNCE == 1;
                    end
                end
                default: begin
                    if (all_hi) begin
                        cnt_d = cnt_q + 4'd1;
                        rls   = cnt_d == 4'(DEBOUNCE);
                    end else begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
            endcase
        end
        if (acc) begin
            press_d = 1'b1;
            code_d  = code;
            kv_d    = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
        end
        if (rls) begin
            press_d = 1'b0;
            rel_d   = 1'b1;
            adv     = 1'b1;
            cnt_d   = '0;
            state_d = SCAN;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN;
            s1_q    <= '1;
            krs_q   <= '1;
            cand_q  <= '1;
            div_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            press_q <= 1'b0;
            kv_q    <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= kp.kr;
            krs_q   <= s1_q;
            cand_q  <= cand_d;
            div_q   <= (tick || adv) ? '0 : div_q + DW'(1);
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            press_q <= press_d;
            kv_q    <= kv_d;
            rel_q   <= rel_d;
        end
    end
endmodule
